// File: rtl/tomasulo_rs_n.sv
// Tomasulo reservation station with ENTRIES slots.
// Each entry holds one issued instruction and snoops the CDB for its pending operands.
// The station dispatches the oldest ready entry whenever the FU can accept one.
// An entry stays occupied until its own result label is broadcast on the CDB.
module tomasulo_rs_n #(
  parameter int ENTRIES    = 3,
  parameter int DATA_W     = 32,
  parameter int LABEL_W    = 4,
  parameter int OP_W       = 2,
  parameter int LABEL_BASE = 1
) (
  input  logic                         clk,
  input  logic                         nRST,
  input  logic                         WEN,
  input  logic [OP_W-1:0]              opCode,
  input  logic [DATA_W-1:0]            dataIn1,
  input  logic [LABEL_W-1:0]           label1,
  input  logic [DATA_W-1:0]            dataIn2,
  input  logic [LABEL_W-1:0]           label2,
  input  logic                         BCEN,
  input  logic [LABEL_W-1:0]           BClabel,
  input  logic [DATA_W-1:0]            BCdata,
  input  logic                         EXEable,
  input  logic                         flush,
  output logic                         isFull,
  output logic [LABEL_W-1:0]           writeable_labelOut,
  output logic [OP_W-1:0]              opOut,
  output logic [DATA_W-1:0]            dataOut1,
  output logic [DATA_W-1:0]            dataOut2,
  output logic                         OutEn,
  output logic [LABEL_W-1:0]           ready_labelOut,
  output logic [$clog2(ENTRIES+1)-1:0] occupancy
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int OCC_W = $clog2(ENTRIES + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_EXEC} ent_state_e;

  // Per-entry control state and age relation.
  // older_q[i][j] is set when entry i was allocated before entry j.
  ent_state_e         state_q [ENTRIES];
  ent_state_e         state_d [ENTRIES];
  logic [ENTRIES-1:0] older_q [ENTRIES];
  logic [ENTRIES-1:0] older_d [ENTRIES];

  // Per-entry payload
  logic [OP_W-1:0]    op_q [ENTRIES];
  logic [OP_W-1:0]    op_d [ENTRIES];
  logic [DATA_W-1:0]  v1_q [ENTRIES];
  logic [DATA_W-1:0]  v1_d [ENTRIES];
  logic [DATA_W-1:0]  v2_q [ENTRIES];
  logic [DATA_W-1:0]  v2_d [ENTRIES];
  logic [LABEL_W-1:0] q1_q [ENTRIES];
  logic [LABEL_W-1:0] q1_d [ENTRIES];
  logic [LABEL_W-1:0] q2_q [ENTRIES];
  logic [LABEL_W-1:0] q2_d [ENTRIES];

  // Dispatch port and occupancy registers
  logic               out_en_q, out_en_d;
  logic [OP_W-1:0]    op_out_q, op_out_d;
  logic [DATA_W-1:0]  data1_q, data1_d;
  logic [DATA_W-1:0]  data2_q, data2_d;
  logic [LABEL_W-1:0] rdy_label_q, rdy_label_d;
  logic [OCC_W-1:0]   occ_q, occ_d;

  logic alloc_found, disp_found, is_oldest;
  idx_t alloc_idx, disp_idx;
  logic do_alloc, do_disp;
  logic byp1, byp2;
  logic [LABEL_W-1:0] new_q1, new_q2;

  function automatic logic [LABEL_W-1:0] own_label(input int i);
    return LABEL_W'(LABEL_BASE + i);
  endfunction

  // Allocation target: the lowest-index FREE entry in the registered state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (state_q[i] == ST_FREE) begin
        alloc_found = 1'b1;
        alloc_idx   = idx_t'(i);
      end
    end
  end

  // Dispatch candidate: the READY entry that is older than every other READY entry.
  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
    is_oldest  = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      is_oldest = (state_q[i] == ST_READY);
      for (int j = 0; j < ENTRIES; j++) begin
        if (j != i && state_q[j] == ST_READY && !older_q[i][j]) is_oldest = 1'b0;
      end
      if (is_oldest) begin
        disp_found = 1'b1;
        disp_idx   = idx_t'(i);
      end
    end
  end

  assign do_alloc = WEN && alloc_found && !flush;
  assign do_disp  = EXEable && disp_found && !flush;

  // Issue-cycle CDB bypass: an operand whose producer is broadcasting now is captured directly.
  assign byp1   = BCEN && (label1 != '0) && (label1 == BClabel);
  assign byp2   = BCEN && (label2 != '0) && (label2 == BClabel);
  assign new_q1 = byp1 ? '0 : label1;
  assign new_q2 = byp2 ? '0 : label2;

  // Entry next state: flush, CDB wakeup, dispatch, free and allocation.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later statements see earlier results; flops below use '<='.
    state_d = state_q;
    older_d = older_q;
    op_d    = op_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    q1_d    = q1_q;
    q2_d    = q2_q;
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_d[i] = ST_FREE;
        older_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        case (state_q[i])
          ST_WAIT: begin
            if (BCEN && q1_q[i] != '0 && q1_q[i] == BClabel) begin
              v1_d[i] = BCdata;
              q1_d[i] = '0;
            end
            if (BCEN && q2_q[i] != '0 && q2_q[i] == BClabel) begin
              v2_d[i] = BCdata;
              q2_d[i] = '0;
            end
            if (q1_d[i] == '0 && q2_d[i] == '0) state_d[i] = ST_READY;
          end
          ST_READY: if (do_disp && disp_idx == idx_t'(i)) state_d[i] = ST_EXEC;
          ST_EXEC:  if (BCEN && BClabel == own_label(i)) state_d[i] = ST_FREE;
          default: ;
        endcase
      end
      if (do_alloc) begin
        op_d[alloc_idx]    = opCode;
        v1_d[alloc_idx]    = byp1 ? BCdata : dataIn1;
        v2_d[alloc_idx]    = byp2 ? BCdata : dataIn2;
        q1_d[alloc_idx]    = new_q1;
        q2_d[alloc_idx]    = new_q2;
        state_d[alloc_idx] = (new_q1 == '0 && new_q2 == '0) ? ST_READY : ST_WAIT;
        // The new entry is younger than every other entry.
        for (int j = 0; j < ENTRIES; j++) begin
          older_d[alloc_idx][j] = 1'b0;
          older_d[j][alloc_idx] = (idx_t'(j) != alloc_idx);
        end
      end
    end
  end

  // Dispatch port: load from the selected entry, otherwise hold the data and drop the pulse.
  always_comb begin
    out_en_d    = do_disp;
    op_out_d    = op_out_q;
    data1_d     = data1_q;
    data2_d     = data2_q;
    rdy_label_d = rdy_label_q;
    if (do_disp) begin
      op_out_d    = op_q[disp_idx];
      data1_d     = v1_q[disp_idx];
      data2_d     = v2_q[disp_idx];
      rdy_label_d = LABEL_W'(LABEL_BASE) + LABEL_W'(disp_idx);
    end
  end

  // Occupancy after this cycle's allocation, frees and flush.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (state_d[i] != ST_FREE) occ_d = occ_d + OCC_W'(1);
    end
  end

  // Control, age and output registers, cleared by reset.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_q[i] <= ST_FREE;
        older_q[i] <= '0;
      end
      out_en_q    <= 1'b0;
      op_out_q    <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      rdy_label_q <= '0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      older_q     <= older_d;
      out_en_q    <= out_en_d;
      op_out_q    <= op_out_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      rdy_label_q <= rdy_label_d;
      occ_q       <= occ_d;
    end
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    // NOTE: payload is not reset; it is only read from non-FREE entries, and every allocation rewrites it.
    op_q <= op_d;
    v1_q <= v1_d;
    v2_q <= v2_d;
    q1_q <= q1_d;
    q2_q <= q2_d;
  end

  assign isFull             = !alloc_found;
  assign writeable_labelOut = alloc_found ? (LABEL_W'(LABEL_BASE) + LABEL_W'(alloc_idx)) : '0;
  assign OutEn              = out_en_q;
  assign opOut              = op_out_q;
  assign dataOut1           = data1_q;
  assign dataOut2           = data2_q;
  assign ready_labelOut     = rdy_label_q;
  assign occupancy          = occ_q;

endmodule

// File: tb/tb_tomasulo_rs_n.sv
// Self-checking bench for tomasulo_rs_n.
// Directed scenarios are followed by a randomized run.
// The randomized run is compared against a queue-based reference model.
module tb_tomasulo_rs_n;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int OW = 2;
  localparam int LB = 1;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          nRST = 1'b1;
  logic          WEN, BCEN, EXEable, flush;
  logic [OW-1:0] opCode;
  logic [DW-1:0] dataIn1, dataIn2, BCdata;
  logic [LW-1:0] label1, label2, BClabel;
  logic          isFull, OutEn;
  logic [LW-1:0] writeable_labelOut, ready_labelOut;
  logic [OW-1:0] opOut;
  logic [DW-1:0] dataOut1, dataOut2;
  logic [CW-1:0] occupancy;

  int tests = 0;
  int fails = 0;

  tomasulo_rs_n #(
    .ENTRIES(N), .DATA_W(DW), .LABEL_W(LW), .OP_W(OW), .LABEL_BASE(LB)
  ) dut (
    .clk(clk), .nRST(nRST), .WEN(WEN), .opCode(opCode),
    .dataIn1(dataIn1), .label1(label1), .dataIn2(dataIn2), .label2(label2),
    .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata), .EXEable(EXEable), .flush(flush),
    .isFull(isFull), .writeable_labelOut(writeable_labelOut), .opOut(opOut),
    .dataOut1(dataOut1), .dataOut2(dataOut2), .OutEn(OutEn),
    .ready_labelOut(ready_labelOut), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Reference model: entry contents plus a queue of entry indices in allocation order.
  typedef enum logic [1:0] {M_FREE, M_WAIT, M_READY, M_EXEC} m_st_e;
  typedef struct packed {
    m_st_e         st;
    logic [OW-1:0] op;
    logic [DW-1:0] v1;
    logic [LW-1:0] q1;
    logic [DW-1:0] v2;
    logic [LW-1:0] q2;
  } m_ent_t;

  m_ent_t        m_ent [N];
  int            m_order[$];
  logic          m_outen;
  logic [OW-1:0] m_op;
  logic [DW-1:0] m_d1, m_d2;
  logic [LW-1:0] m_rl;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_ent[i] = '0;
    m_order.delete();
    m_outen = 1'b0;
    m_op    = '0;
    m_d1    = '0;
    m_d2    = '0;
    m_rl    = '0;
  endfunction

  function automatic int m_free_idx();
    for (int i = 0; i < N; i++) if (m_ent[i].st == M_FREE) return i;
    return -1;
  endfunction

  function automatic logic [LW-1:0] m_writeable();
    int f;
    f = m_free_idx();
    return (f < 0) ? '0 : LW'(LB + f);
  endfunction

  // One rising edge of the reference model, using the inputs currently applied.
  function automatic void model_edge();
    m_ent_t nxt [N];
    int alloc_i, disp_i, kdel;
    if (flush) begin
      for (int i = 0; i < N; i++) m_ent[i].st = M_FREE;
      m_order.delete();
      m_outen = 1'b0;
      return;
    end
    alloc_i = WEN ? m_free_idx() : -1;
    disp_i  = -1;
    if (EXEable) begin
      foreach (m_order[k]) if (disp_i < 0 && m_ent[m_order[k]].st == M_READY) disp_i = m_order[k];
    end
    nxt = m_ent;
    for (int i = 0; i < N; i++) begin
      if (m_ent[i].st == M_WAIT) begin
        if (BCEN && m_ent[i].q1 != 0 && m_ent[i].q1 == BClabel) begin nxt[i].v1 = BCdata; nxt[i].q1 = '0; end
        if (BCEN && m_ent[i].q2 != 0 && m_ent[i].q2 == BClabel) begin nxt[i].v2 = BCdata; nxt[i].q2 = '0; end
        if (nxt[i].q1 == 0 && nxt[i].q2 == 0) nxt[i].st = M_READY;
      end
      if (m_ent[i].st == M_EXEC && BCEN && BClabel == LW'(LB + i)) begin
        nxt[i].st = M_FREE;
        kdel = -1;
        foreach (m_order[k]) if (m_order[k] == i) kdel = k;
        if (kdel >= 0) m_order.delete(kdel);
      end
    end
    if (disp_i >= 0) begin
      nxt[disp_i].st = M_EXEC;
      m_outen = 1'b1;
      m_op    = m_ent[disp_i].op;
      m_d1    = m_ent[disp_i].v1;
      m_d2    = m_ent[disp_i].v2;
      m_rl    = LW'(LB + disp_i);
    end else begin
      m_outen = 1'b0;
    end
    if (alloc_i >= 0) begin
      nxt[alloc_i].op = opCode;
      nxt[alloc_i].v1 = (BCEN && label1 != 0 && label1 == BClabel) ? BCdata : dataIn1;
      nxt[alloc_i].q1 = (BCEN && label1 != 0 && label1 == BClabel) ? '0 : label1;
      nxt[alloc_i].v2 = (BCEN && label2 != 0 && label2 == BClabel) ? BCdata : dataIn2;
      nxt[alloc_i].q2 = (BCEN && label2 != 0 && label2 == BClabel) ? '0 : label2;
      nxt[alloc_i].st = (nxt[alloc_i].q1 == 0 && nxt[alloc_i].q2 == 0) ? M_READY : M_WAIT;
      m_order.push_back(alloc_i);
    end
    m_ent = nxt;
  endfunction

  // Stimulus helpers
  task automatic step();
    @(posedge clk);
    if (!nRST) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic idle();
    WEN = 1'b0; BCEN = 1'b0; flush = 1'b0; BClabel = '0; BCdata = '0;
    opCode = '0; dataIn1 = '0; dataIn2 = '0; label1 = '0; label2 = '0;
  endtask

  task automatic issue(input logic [OW-1:0] op, input logic [DW-1:0] d1, input logic [LW-1:0] l1,
                       input logic [DW-1:0] d2, input logic [LW-1:0] l2);
    WEN = 1'b1; opCode = op; dataIn1 = d1; label1 = l1; dataIn2 = d2; label2 = l2;
  endtask

  task automatic broadcast(input logic [LW-1:0] l, input logic [DW-1:0] d);
    BCEN = 1'b1; BClabel = l; BCdata = d;
  endtask

  task automatic do_reset();
    idle();
    EXEable = 1'b0;
    nRST = 1'b1;
    #1 nRST = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 nRST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (OutEn !== 1'b0) begin fails++; $display("FAIL reset_outen: got %0b want 0", OutEn); end
    tests++; if (opOut !== '0) begin fails++; $display("FAIL reset_op: got %0h want 0", opOut); end
    tests++; if (dataOut1 !== '0 || dataOut2 !== '0) begin fails++; $display("FAIL reset_data: got %0h/%0h want 0/0", dataOut1, dataOut2); end
    tests++; if (ready_labelOut !== '0) begin fails++; $display("FAIL reset_rlabel: got %0h want 0", ready_labelOut); end
    tests++; if (occupancy !== '0) begin fails++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    tests++; if (isFull !== 1'b0) begin fails++; $display("FAIL reset_full: got %0b want 0", isFull); end
    tests++; if (writeable_labelOut !== LW'(LB)) begin fails++; $display("FAIL reset_wlabel: got %0d want %0d", writeable_labelOut, LB); end
  endtask

  task automatic test_basic();
    do_reset();
    EXEable = 1'b1;
    issue(2'd1, 32'd5, 4'd0, 32'd7, 4'd0);
    tests++; if (writeable_labelOut !== 4'd1) begin fails++; $display("FAIL basic_wlabel: got %0d want 1", writeable_labelOut); end
    step(); idle();
    tests++; if (OutEn !== 1'b0) begin fails++; $display("FAIL basic_nodisp_issue: got %0b want 0", OutEn); end
    step();
    tests++; if (OutEn !== 1'b1 || opOut !== 2'd1 || ready_labelOut !== 4'd1) begin fails++; $display("FAIL basic_disp: got en=%0b op=%0d lbl=%0d want 1/1/1", OutEn, opOut, ready_labelOut); end
    tests++; if (dataOut1 !== 32'd5 || dataOut2 !== 32'd7) begin fails++; $display("FAIL basic_data: got %0d/%0d want 5/7", dataOut1, dataOut2); end
    step();
    tests++; if (OutEn !== 1'b0 || occupancy !== CW'(1)) begin fails++; $display("FAIL basic_exec_hold: got en=%0b occ=%0d want 0/1", OutEn, occupancy); end
    broadcast(4'd1, 32'h1234); step(); idle();
    tests++; if (occupancy !== '0 || writeable_labelOut !== 4'd1) begin fails++; $display("FAIL basic_free: got occ=%0d wl=%0d want 0/1", occupancy, writeable_labelOut); end
  endtask

  task automatic test_wakeup();
    do_reset();
    EXEable = 1'b1;
    issue(2'd2, 32'hDEAD, 4'd2, 32'd3, 4'd0);
    step(); idle(); step(); step();
    tests++; if (OutEn !== 1'b0) begin fails++; $display("FAIL wake_wait_nodisp: got %0b want 0", OutEn); end
    broadcast(4'd2, 32'h10); step(); idle();
    tests++; if (OutEn !== 1'b0) begin fails++; $display("FAIL wake_capture_nodisp: got %0b want 0", OutEn); end
    step();
    tests++; if (OutEn !== 1'b1 || dataOut1 !== 32'h10 || dataOut2 !== 32'd3 || ready_labelOut !== 4'd1) begin
      fails++; $display("FAIL wake_disp: got en=%0b d1=%0h d2=%0h lbl=%0d want 1/10/3/1", OutEn, dataOut1, dataOut2, ready_labelOut); end
  endtask

  task automatic test_bypass();
    do_reset();
    EXEable = 1'b1;
    issue(2'd3, 32'd4, 4'd0, 32'h55, 4'd3);
    broadcast(4'd3, 32'd9);
    step(); idle(); step();
    tests++; if (OutEn !== 1'b1 || dataOut1 !== 32'd4 || dataOut2 !== 32'd9 || opOut !== 2'd3) begin
      fails++; $display("FAIL bypass_disp: got en=%0b d1=%0h d2=%0h op=%0d want 1/4/9/3", OutEn, dataOut1, dataOut2, opOut); end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < N; k++) begin
      issue(OW'(k), 32'h100 + 32'(k), 4'd0, 32'h200 + 32'(k), 4'd0);
      step();
    end
    tests++; if (isFull !== 1'b1 || writeable_labelOut !== '0 || occupancy !== CW'(3)) begin
      fails++; $display("FAIL full_flags: got full=%0b wl=%0d occ=%0d want 1/0/3", isFull, writeable_labelOut, occupancy); end
    issue(2'd0, 32'hBAD, 4'd0, 32'hBAD, 4'd0); step(); idle();
    tests++; if (occupancy !== CW'(3)) begin fails++; $display("FAIL full_ignore: got occ=%0d want 3", occupancy); end
    EXEable = 1'b1; step();
    tests++; if (ready_labelOut !== 4'd1 || dataOut1 !== 32'h100) begin fails++; $display("FAIL full_disp1: got lbl=%0d d1=%0h want 1/100", ready_labelOut, dataOut1); end
    step(); EXEable = 1'b0;
    tests++; if (ready_labelOut !== 4'd2 || dataOut1 !== 32'h101) begin fails++; $display("FAIL full_disp2: got lbl=%0d d1=%0h want 2/101", ready_labelOut, dataOut1); end
    broadcast(4'd2, 32'd0); issue(2'd1, 32'h300, 4'd0, 32'h301, 4'd0); step(); idle();
    tests++; if (occupancy !== CW'(2) || isFull !== 1'b0 || writeable_labelOut !== 4'd2) begin
      fails++; $display("FAIL full_free_next: got occ=%0d full=%0b wl=%0d want 2/0/2", occupancy, isFull, writeable_labelOut); end
    issue(2'd1, 32'h300, 4'd0, 32'h301, 4'd0); step(); idle();
    tests++; if (occupancy !== CW'(3) || isFull !== 1'b1) begin fails++; $display("FAIL full_realloc: got occ=%0d full=%0b want 3/1", occupancy, isFull); end
    broadcast(4'd1, 32'd0); step(); idle();
    EXEable = 1'b1; step();
    tests++; if (ready_labelOut !== 4'd3 || dataOut1 !== 32'h102) begin fails++; $display("FAIL full_age: got lbl=%0d d1=%0h want 3/102", ready_labelOut, dataOut1); end
  endtask

  task automatic test_age();
    logic [LW-1:0] exp_lbl [3];
    logic [DW-1:0] exp_d1 [3];
    exp_lbl = '{4'd3, 4'd1, 4'd2};
    exp_d1  = '{32'hA2, 32'hB0, 32'hB1};
    do_reset();
    issue(2'd0, 32'hA0, 4'd0, 32'd0, 4'd0); step();
    issue(2'd0, 32'hA1, 4'd0, 32'd0, 4'd0); step(); idle();
    EXEable = 1'b1; step(); step(); EXEable = 1'b0;
    issue(2'd0, 32'hA2, 4'd0, 32'd0, 4'd0); step(); idle();
    broadcast(4'd1, 32'd0); step();
    broadcast(4'd2, 32'd0); step(); idle();
    issue(2'd0, 32'hB0, 4'd0, 32'd0, 4'd0); step();
    issue(2'd0, 32'hB1, 4'd0, 32'd0, 4'd0); step(); idle();
    tests++; if (writeable_labelOut !== '0) begin fails++; $display("FAIL age_setup_full: got wl=%0d want 0", writeable_labelOut); end
    EXEable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if (OutEn !== 1'b1 || ready_labelOut !== exp_lbl[k] || dataOut1 !== exp_d1[k]) begin
        fails++; $display("FAIL age_order[%0d]: got en=%0b lbl=%0d d1=%0h want 1/%0d/%0h", k, OutEn, ready_labelOut, dataOut1, exp_lbl[k], exp_d1[k]); end
    end
    EXEable = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    EXEable = 1'b1;
    issue(2'd1, 32'hAA, 4'd0, 32'hBB, 4'd0); step();
    issue(2'd2, 32'd0, 4'd9, 32'd1, 4'd0); step();
    issue(2'd2, 32'd2, 4'd0, 32'd0, 4'd9); step(); idle();
    tests++; if (occupancy !== CW'(3)) begin fails++; $display("FAIL flush_setup: got occ=%0d want 3", occupancy); end
    issue(2'd3, 32'hCC, 4'd0, 32'hCC, 4'd0); broadcast(4'd9, 32'h77); flush = 1'b1;
    step(); idle();
    tests++; if (occupancy !== '0 || isFull !== 1'b0 || OutEn !== 1'b0 || writeable_labelOut !== 4'd1) begin
      fails++; $display("FAIL flush_clear: got occ=%0d full=%0b en=%0b wl=%0d want 0/0/0/1", occupancy, isFull, OutEn, writeable_labelOut); end
    tests++; if (dataOut1 !== 32'hAA || dataOut2 !== 32'hBB) begin fails++; $display("FAIL flush_data_hold: got %0h/%0h want aa/bb", dataOut1, dataOut2); end
    broadcast(4'd9, 32'h88); step(); idle(); step(); step();
    tests++; if (OutEn !== 1'b0 || occupancy !== '0) begin fails++; $display("FAIL flush_no_wake: got en=%0b occ=%0d want 0/0", OutEn, occupancy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    EXEable = 1'b1;
    issue(2'd1, 32'h11, 4'd0, 32'h22, 4'd0); step(); idle();
    #2 nRST = 1'b0;
    #1;
    model_reset();
    tests++; if (occupancy !== '0 || isFull !== 1'b0 || OutEn !== 1'b0 || writeable_labelOut !== 4'd1) begin
      fails++; $display("FAIL midreset_async: got occ=%0d full=%0b en=%0b wl=%0d want 0/0/0/1", occupancy, isFull, OutEn, writeable_labelOut); end
    step();
    nRST = 1'b1;
    step();
    tests++; if (OutEn !== 1'b0 || occupancy !== '0) begin fails++; $display("FAIL midreset_nopulse: got en=%0b occ=%0d want 0/0", OutEn, occupancy); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      WEN     = 1'($urandom_range(0, 1));
      opCode  = OW'($urandom);
      dataIn1 = DW'($urandom);
      dataIn2 = DW'($urandom);
      label1  = ($urandom_range(0, 1) == 0) ? '0 : LW'($urandom_range(1, 5));
      label2  = ($urandom_range(0, 1) == 0) ? '0 : LW'($urandom_range(1, 5));
      BCEN    = 1'($urandom_range(0, 1));
      BClabel = LW'($urandom_range(0, 5));
      BCdata  = DW'($urandom);
      EXEable = ($urandom_range(0, 9) < 6);
      flush   = ($urandom_range(0, 49) == 0);
      step();
      tests++; if (OutEn !== m_outen) begin fails++; $display("FAIL rand_outen c%0d: got %0b want %0b", c, OutEn, m_outen); end
      tests++; if (opOut !== m_op) begin fails++; $display("FAIL rand_op c%0d: got %0h want %0h", c, opOut, m_op); end
      tests++; if (dataOut1 !== m_d1) begin fails++; $display("FAIL rand_d1 c%0d: got %0h want %0h", c, dataOut1, m_d1); end
      tests++; if (dataOut2 !== m_d2) begin fails++; $display("FAIL rand_d2 c%0d: got %0h want %0h", c, dataOut2, m_d2); end
      tests++; if (ready_labelOut !== m_rl) begin fails++; $display("FAIL rand_rlabel c%0d: got %0d want %0d", c, ready_labelOut, m_rl); end
      tests++; if (occupancy !== CW'(m_order.size())) begin fails++; $display("FAIL rand_occ c%0d: got %0d want %0d", c, occupancy, m_order.size()); end
      tests++; if (isFull !== (m_order.size() == N)) begin fails++; $display("FAIL rand_full c%0d: got %0b want %0b", c, isFull, m_order.size() == N); end
      tests++; if (writeable_labelOut !== m_writeable()) begin fails++; $display("FAIL rand_wlabel c%0d: got %0d want %0d", c, writeable_labelOut, m_writeable()); end
    end
    idle();
  endtask

  initial begin
    idle();
    EXEable = 1'b0;
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full();
    test_age();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tomasulo_rs_n.md
Name: tomasulo_rs_n

Overview:
- Parametrised reservation station for the Tomasulo core. It holds ENTRIES issued instructions per functional unit and snoops the CDB for pending operands.
- Dispatches the oldest ready entry to its functional unit (FU) when the FU reports EXEable.
- Frees an entry only when its own result label is broadcast.
- Adds over the previous station: configurable depth, widths and label base; age-ordered dispatch; same-cycle CDB bypass on issue; an occupancy count; a synchronous flush.

Parameters:
- ENTRIES, 3, number of station entries (1..8).
- DATA_W, 32, operand and CDB data width.
- LABEL_W, 4, label width; label 0 means "value present".
- OP_W, 2, FU opcode width.
- LABEL_BASE, 1, label of entry 0; entry i owns label LABEL_BASE+i. Must satisfy LABEL_BASE>=1 and LABEL_BASE+ENTRIES-1 <= 2^LABEL_W-1.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- nRST  in  1  asynchronous active-low reset.
- WEN  in  1  issue strobe from the control unit.
- opCode  in  OP_W  opcode of the issued instruction.
- dataIn1  in  DATA_W  Vj.
- label1  in  LABEL_W  Qj; 0 means Vj is valid.
- dataIn2  in  DATA_W  Vk.
- label2  in  LABEL_W  Qk; 0 means Vk is valid.
- BCEN  in  1  CDB valid.
- BClabel  in  LABEL_W  CDB label.
- BCdata  in  DATA_W  CDB data.
- EXEable  in  1  FU can accept an operation this cycle.
- flush  in  1  synchronous clear of all entries.
- isFull  out  1  no FREE entry.
- writeable_labelOut  out  LABEL_W  label the next issue will receive; 0 when full.
- opOut  out  OP_W  dispatched opcode.
- dataOut1  out  DATA_W  dispatched Vj.
- dataOut2  out  DATA_W  dispatched Vk.
- OutEn  out  1  one-cycle dispatch pulse.
- ready_labelOut  out  LABEL_W  label of the dispatched entry.
- occupancy  out  $clog2(ENTRIES+1)  number of non-FREE entries.

Behaviour:
- Reset (nRST=0, asynchronous):
  - all entries FREE, all age state cleared;
  - OutEn=0; opOut, dataOut1, dataOut2, ready_labelOut = 0;
  - occupancy=0, isFull=0, writeable_labelOut=LABEL_BASE.
  - Reset asserted mid-operation discards all entries; no pulse is produced.
- Per-entry states:
  - FREE -> WAIT on allocation when either operand label is nonzero after bypass.
  - FREE -> READY on allocation when both operand labels are 0 after bypass.
  - WAIT -> READY when the last pending operand is captured from the CDB.
  - READY -> EXEC on dispatch.
  - EXEC -> FREE when BCEN=1 and BClabel equals the entry's own label.
  - A broadcast of its own label while the entry is in WAIT or READY is illegal; the entry ignores it.
- Allocation:
  - Target is the lowest-index FREE entry, chosen from current state.
  - writeable_labelOut and isFull are combinational from registered state only.
  - WEN while isFull=1 is ignored; no state change.
  - An entry freed in cycle t is allocatable from cycle t+1.
- Issue bypass: if BCEN=1 and label1==BClabel (nonzero) in the WEN cycle, the entry stores Vj=BCdata, Qj=0. The same rule applies independently to operand 2.
- Snooping: every WAIT entry compares both Q fields against BClabel each cycle BCEN=1. On a match it captures BCdata and clears that Q. Both operands may match in the same cycle.
- Dispatch:
  - Candidates are entries READY at the start of the cycle.
  - When EXEable=1 and a candidate exists, the oldest READY entry (earliest allocation) is selected at the edge.
  - Next cycle: OutEn=1 with opOut, dataOut1, dataOut2, ready_labelOut registered from that entry.
  - Otherwise OutEn=0; data outputs hold their last values.
  - At most one dispatch per cycle.
  - An entry that becomes READY in cycle t (by wakeup or allocation) is first eligible in cycle t+1.
- Age: must be a strict total order over non-FREE entries (age matrix or sequence counters). Order does not wrap incorrectly across any number of allocations.
- Simultaneous events: issue, wakeup, dispatch and free all act in one cycle on distinct entries without interference.
- occupancy: counts allocations minus frees, registered. Equals ENTRIES exactly when isFull=1.
- flush=1 (synchronous, overrides WEN, BCEN and dispatch in that cycle):
  - all entries FREE, OutEn=0 next cycle, occupancy=0;
  - data outputs are not cleared.

Test Plan:
- Defaults, reset then WEN with op=1, Vj=5, Qj=0, Vk=7, Qk=0, EXEable=1 -> writeable_labelOut=1 during issue; the cycle after issue, dispatch occurs; the next cycle OutEn=1, opOut=1, dataOut1=5, dataOut2=7, ready_labelOut=1; entry stays occupied (occupancy=1) until BCEN with BClabel=1, then occupancy=0.
- Issue Qj=2 (pending) into entry 0; later BCEN, BClabel=2, BCdata=0x10 -> dispatch one cycle after capture, dataOut1=0x10.
- Issue with label2=3 while BCEN=1, BClabel=3, BCdata=9 -> entry immediately READY, dataOut2=9 on dispatch.
- Fill 3 entries with EXEable=0 -> isFull=1, writeable_labelOut=0, occupancy=3; a fourth WEN is ignored; broadcast label 2 while entry 2 is in EXEC -> label 2 becomes writeable next cycle.
- Allocate entries 2, 0, 1 in that order, all ready, hold EXEable=0, then EXEable=1 for 3 cycles -> ready_labelOut sequence 3, 1, 2.
- Two entries WAIT, assert flush together with WEN -> next cycle occupancy=0, isFull=0, OutEn=0; later CDB broadcasts do not wake anything.
